// File: rtl/spm_b_arbiter.sv
// SPM port B arbiter: MEM-stage priority with a DMA starvation guard.
// Also tracks the owner of the in-flight read and steers the returned data to it.
module spm_b_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              mem_as_,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_busy,
  input  logic              dma_req,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wr_data,
  output logic              dma_ack,
  output logic              dma_rd_valid,
  output logic [DATA_W-1:0] dma_rd_data,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
  localparam logic RD = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_MEM  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t           rd_owner, rd_owner_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             force_dma, gnt_dma, gnt_mem;

  // Per-cycle grant: DMA wins on an idle MEM, or once it has waited long enough
  always_comb begin
    force_dma = (wait_cnt == WAIT_MAX);
    gnt_dma   = dma_req & (mem_as_ | force_dma);
    gnt_mem   = ~mem_as_ & ~gnt_dma;
  end

  // Port B mux; an idle port parks as a READ with MEM address/data
  always_comb begin
    spm_as_     = ~(gnt_mem | gnt_dma);
    spm_rw      = RD;
    spm_addr    = mem_addr;
    spm_wr_data = mem_wr_data;
    if (gnt_dma) begin
      spm_rw      = dma_rw;
      spm_addr    = dma_addr;
      spm_wr_data = dma_wr_data;
    end else if (gnt_mem) begin
      spm_rw      = mem_rw;
    end
    mem_busy    = ~mem_as_ & gnt_dma;
    dma_ack     = gnt_dma;
    mem_rd_data = (rd_owner == OWN_MEM) ? spm_rd_data : '0;
  end

  // Starvation counter and read-owner next state
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    rd_owner_nxt = OWN_NONE;
    if (!dma_req || gnt_dma) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
    if (gnt_dma && (dma_rw == RD)) begin
      rd_owner_nxt = OWN_DMA;
    end else if (gnt_mem && (mem_rw == RD)) begin
      rd_owner_nxt = OWN_MEM;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      rd_owner <= rd_owner_nxt;
    end
  end

  // DMA read return: capture one cycle after the SPM address phase
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      dma_rd_valid <= 1'b0;
      dma_rd_data  <= '0;
    end else begin
      dma_rd_valid <= (rd_owner == OWN_DMA);
      if (rd_owner == OWN_DMA) begin
        dma_rd_data <= spm_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spm_b_arbiter.sv
// Bench for spm_b_arbiter: directed literal scenarios, then random traffic
// checked every cycle against a transaction-level model with an SPM memory model.
module tb_spm_b_arbiter;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset_;
  logic              mem_as_, mem_rw, dma_req, dma_rw;
  logic [ADDR_W-1:0] mem_addr, dma_addr;
  logic [DATA_W-1:0] mem_wr_data, dma_wr_data;
  logic [DATA_W-1:0] mem_rd_data, dma_rd_data, spm_wr_data, spm_rd_data;
  logic              mem_busy, dma_ack, dma_rd_valid, spm_as_, spm_rw;
  logic [ADDR_W-1:0] spm_addr;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] gold [4096];

  spm_b_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_(reset_),
    .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_busy(mem_busy),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
    .dma_ack(dma_ack), .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
    .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  always #5 clk = ~clk;

  // SPM port B: 1-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin
    if (!spm_as_ && spm_rw) spm_rd_data <= gold[spm_addr];
    else                    spm_rd_data <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: denial count, pending read owner + data, DMA return regs
  int          m_den = 0;
  int          m_own = 0;
  int          n_own;
  logic [31:0] m_pend = '0, n_pend;
  logic        m_dv = 1'b0;
  logic [31:0] m_dd = '0;
  logic        e_dg, e_mg, e_rw;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wd;

  always @(negedge clk) begin
    if (!reset_) begin
      m_den = 0; m_own = 0; m_dv = 1'b0; m_dd = '0;
    end
    e_dg   = dma_req && (mem_as_ || (m_den >= int'(MAX_WAIT)));
    e_mg   = !mem_as_ && !e_dg;
    e_rw   = e_dg ? dma_rw : (e_mg ? mem_rw : 1'b1);
    e_addr = e_dg ? dma_addr : mem_addr;
    e_wd   = e_dg ? dma_wr_data : mem_wr_data;
    chk("dma_ack",      32'(dma_ack),      32'(e_dg));
    chk("mem_busy",     32'(mem_busy),     32'(!mem_as_ && e_dg));
    chk("spm_as_",      32'(spm_as_),      32'(!(e_dg || e_mg)));
    chk("spm_rw",       32'(spm_rw),       32'(e_rw));
    chk("spm_addr",     32'(spm_addr),     32'(e_addr));
    chk("spm_wr_data",  spm_wr_data,       e_wd);
    chk("mem_rd_data",  mem_rd_data,       (m_own == 1) ? m_pend : 32'h0);
    chk("dma_rd_valid", 32'(dma_rd_valid), 32'(m_dv));
    chk("dma_rd_data",  dma_rd_data,       m_dd);
    // advance one cycle
    n_own = 0; n_pend = '0;
    if (e_dg && dma_rw)      begin n_own = 2; n_pend = gold[dma_addr]; end
    else if (e_mg && mem_rw) begin n_own = 1; n_pend = gold[mem_addr]; end
    if (e_dg && !dma_rw)      gold[dma_addr] = dma_wr_data;
    else if (e_mg && !mem_rw) gold[mem_addr] = mem_wr_data;
    m_dv = (m_own == 2);
    if (m_own == 2) m_dd = m_pend;
    m_own  = n_own;
    m_pend = n_pend;
    if (!dma_req || e_dg)          m_den = 0;
    else if (m_den < int'(MAX_WAIT)) m_den = m_den + 1;
    if (!reset_) begin
      m_den = 0; m_own = 0; m_dv = 1'b0; m_dd = '0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_as_ = 1'b1; mem_rw = 1'b1; mem_addr = '0; mem_wr_data = '0;
    dma_req = 1'b0; dma_rw = 1'b1; dma_addr = '0; dma_wr_data = '0;
  endtask

  task automatic mem_rd(input logic [ADDR_W-1:0] a);
    mem_as_ = 1'b0; mem_rw = 1'b1; mem_addr = a;
  endtask

  logic ack;

  initial begin
    for (int i = 0; i < 4096; i++) gold[i] = $urandom;
    gold[12'h010] = 32'hDEADBEEF;
    gold[12'h030] = 32'hA5A5A5A5;
    gold[12'h031] = 32'h0BADF00D;
    idle();
    reset_ = 1'b0;
    #2;
    chk("rst spm_as_",      32'(spm_as_),      32'd1);
    chk("rst mem_busy",     32'(mem_busy),     32'd0);
    chk("rst dma_ack",      32'(dma_ack),      32'd0);
    chk("rst dma_rd_valid", 32'(dma_rd_valid), 32'd0);
    chk("rst dma_rd_data",  dma_rd_data,       32'd0);
    cyc(); cyc();
    reset_ = 1'b1;
    cyc();

    // 1: MEM read only
    mem_rd(12'h010); #1;
    chk("t1 spm_as_",  32'(spm_as_),  32'd0);
    chk("t1 mem_busy", 32'(mem_busy), 32'd0);
    cyc(); idle(); #1;
    chk("t1 mem_rd_data", mem_rd_data, 32'hDEADBEEF);

    // 2: DMA write on idle bus, then MEM readback
    cyc();
    dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 12'h020; dma_wr_data = 32'h12345678; #1;
    chk("t2 dma_ack", 32'(dma_ack), 32'd1);
    cyc(); idle(); mem_rd(12'h020);
    cyc(); idle(); #1;
    chk("t2 mem_rd_data", mem_rd_data, 32'h12345678);

    // 3: starvation with MEM reading every cycle
    cyc();
    mem_rd(12'h010);
    dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 12'h040; dma_wr_data = 32'h55AA55AA;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t3 dma_ack",  32'(dma_ack),  32'(k == 5));
      chk("t3 mem_busy", 32'(mem_busy), 32'(k == 5));
      cyc();
    end
    dma_req = 1'b0; #1;
    chk("t3 mem_busy after", 32'(mem_busy), 32'd0);
    cyc(); idle();

    // 4: DMA read then MEM read next cycle
    cyc();
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 12'h030; #1;
    chk("t4 dma_ack", 32'(dma_ack), 32'd1);
    cyc(); idle(); mem_rd(12'h031); #1;
    chk("t4 early valid", 32'(dma_rd_valid), 32'd0);
    cyc(); idle(); #1;
    chk("t4 dma_rd_valid", 32'(dma_rd_valid), 32'd1);
    chk("t4 dma_rd_data",  dma_rd_data,       32'hA5A5A5A5);
    chk("t4 mem_rd_data",  mem_rd_data,       32'h0BADF00D);
    cyc(); #1;
    chk("t4 valid pulse", 32'(dma_rd_valid), 32'd0);
    chk("t4 data hold",   dma_rd_data,       32'hA5A5A5A5);

    // 5: reset right after a DMA read ack
    cyc();
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 12'h030;
    cyc(); idle(); reset_ = 1'b0; #1;
    chk("t5 valid in rst", 32'(dma_rd_valid), 32'd0);
    cyc(); reset_ = 1'b1; #1;
    chk("t5 valid after", 32'(dma_rd_valid), 32'd0);
    chk("t5 data after",  dma_rd_data,       32'd0);
    mem_rd(12'h010);
    cyc(); idle(); #1;
    chk("t5 resume", mem_rd_data, 32'hDEADBEEF);

    // 6: withdrawn request restarts the starvation count
    cyc();
    mem_rd(12'h010);
    dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 12'h050; dma_wr_data = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      #1; chk("t6 denied", 32'(dma_ack), 32'd0); cyc();
    end
    dma_req = 1'b0; #1;
    chk("t6 dropped", 32'(dma_ack), 32'd0);
    cyc();
    dma_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1; chk("t6 restart", 32'(dma_ack), 32'(k == 5)); cyc();
    end
    idle();
    cyc();

    // random traffic with DMA hold-until-ack protocol
    ack = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset_      = ($urandom_range(0, 299) != 0);
      mem_as_     = ($urandom_range(0, 9) < 3);
      mem_rw      = $urandom_range(0, 1) == 1;
      mem_addr    = ADDR_W'($urandom_range(0, 63));
      mem_wr_data = $urandom;
      if (!dma_req || ack) begin
        dma_req     = $urandom_range(0, 1) == 1;
        dma_rw      = $urandom_range(0, 1) == 1;
        dma_addr    = ADDR_W'($urandom_range(0, 63));
        dma_wr_data = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        dma_req = 1'b0;
      end
      #3;
      ack = dma_ack;
      cyc();
    end
    reset_ = 1'b1;
    idle();
    cyc(); cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
